// File: rtl/data_mem_ctrl_if.sv
// CPU load/store request bus plus single-port RAM bus seen by the data memory controller.
interface data_mem_ctrl_if #(
   parameter int RAM_AW = 10
);
   logic              mem_re;
   logic              mem_we;
   logic [2:0]        funct3;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [31:0]       load_data;
   logic              load_valid;
   logic              stall;
   logic              misalign_err;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic              ram_we;
   logic [31:0]       ram_dout;

   modport master (
      output mem_re, mem_we, funct3, addr, wdata, ram_dout,
      input  load_data, load_valid, stall, misalign_err, ram_addr, ram_din, ram_we
   );

   modport slave (
      input  mem_re, mem_we, funct3, addr, wdata, ram_dout,
      output load_data, load_valid, stall, misalign_err, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: SW in 1 cycle; loads and SB/SH read-modify-write take 2 cycles.
// Stall is raised in the first cycle of any 2-cycle access; bad accesses set a sticky error.
module data_mem_ctrl #(
   parameter int RAM_AW = 10
) (
   input logic           clk,
   input logic           rst,
   data_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WAIT} state_t;

   state_t            state, state_nxt;
   logic [1:0]        lat_off;
   logic [2:0]        lat_f3;
   logic [31:0]       lat_wdata;
   logic [RAM_AW-1:0] lat_addr;
   logic              misalign_err;

   logic        aligned, ld_ok, st_ok, req_err, err_set;
   logic [4:0]  sh_amt;
   logic [31:0] rd_shift, lane_mask, lane_data, merged, ext_data;
   logic [31:0] load_data, ram_din;
   logic        load_valid, stall, ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic        unused_bits;

   always_comb begin
      case (bus.funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~bus.addr[0];
         2'b10:   aligned = (bus.addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign ld_ok   = aligned & (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign st_ok   = aligned & (bus.funct3 inside {3'b000, 3'b001, 3'b010});
   assign req_err = (bus.mem_re & bus.mem_we) |
                    (bus.mem_re & ~bus.mem_we & ~ld_ok) |
                    (bus.mem_we & ~bus.mem_re & ~st_ok);

   // Halfword offsets are always even, so a byte-granular shift serves both sizes.
   assign sh_amt    = {lat_off, 3'b000};
   assign rd_shift  = bus.ram_dout >> sh_amt;
   assign lane_mask = lat_f3[0] ? (32'h0000_FFFF << sh_amt) : (32'h0000_00FF << sh_amt);
   assign lane_data = lat_f3[0] ? {2{lat_wdata[15:0]}} : {4{lat_wdata[7:0]}};
   assign merged    = (bus.ram_dout & ~lane_mask) | (lane_data & lane_mask);

   always_comb begin
      case (lat_f3)
         3'b000:  ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ext_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  ext_data = {24'd0, rd_shift[7:0]};
         3'b101:  ext_data = {16'd0, rd_shift[15:0]};
         default: ext_data = bus.ram_dout;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      ram_we     = 1'b0;
      ram_din    = bus.wdata;
      ram_addr   = bus.addr[RAM_AW+1:2];
      stall      = 1'b0;
      load_valid = 1'b0;
      load_data  = 32'd0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (req_err) begin
               err_set = 1'b1;
            end else if (bus.mem_we) begin
               if (bus.funct3 == 3'b010) begin
                  ram_we = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = RMW_WAIT;
               end
            end else if (bus.mem_re) begin
               stall     = 1'b1;
               state_nxt = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            ram_addr   = lat_addr;
            load_valid = 1'b1;
            load_data  = ext_data;
            state_nxt  = IDLE;
         end
         RMW_WAIT: begin
            ram_addr  = lat_addr;
            ram_we    = 1'b1;
            ram_din   = merged;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs are forced quiet during reset so an aborted RMW never writes.
      if (rst) begin
         ram_we     = 1'b0;
         stall      = 1'b0;
         load_valid = 1'b0;
         load_data  = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         lat_off      <= 2'd0;
         lat_f3       <= 3'd0;
         lat_wdata    <= 32'd0;
         lat_addr     <= '0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         misalign_err <= misalign_err | err_set;
         if (state == IDLE) begin
            lat_off   <= bus.addr[1:0];
            lat_f3    <= bus.funct3;
            lat_wdata <= bus.wdata;
            lat_addr  <= bus.addr[RAM_AW+1:2];
         end
      end
   end

   assign bus.load_data    = load_data;
   assign bus.load_valid   = load_valid;
   assign bus.stall        = stall;
   assign bus.misalign_err = misalign_err;
   assign bus.ram_addr     = ram_addr;
   assign bus.ram_din      = ram_din;
   assign bus.ram_we       = ram_we;

   assign unused_bits = ^{bus.addr[31:RAM_AW+2], rd_shift[31:16]};
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed-vector bench for data_mem_ctrl with a one-cycle-latency RAM model.
module tb_data_mem_ctrl;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   data_mem_ctrl_if #(.RAM_AW(10)) bus ();

   data_mem_ctrl #(.RAM_AW(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   logic        pre_en;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_val;
      else if (bus.ram_we)
         mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end

   typedef struct {
      string       nm;
      logic        re;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic        two;
      logic        stall0;
      logic        we0;
      logic [31:0] din0;
      logic        we1;
      logic [31:0] din1;
      logic        lv1;
      logic [31:0] ld1;
      logic [31:0] ram_fin;
      logic        err;
   } vec_t;

   vec_t vecs [0:17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
      end
   endtask

   task automatic clear_req();
      bus.mem_re = 1'b0;
      bus.mem_we = 1'b0;
      bus.funct3 = 3'b000;
      bus.addr   = 32'd0;
      bus.wdata  = 32'd0;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(posedge clk); #1;
      clear_req();
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(posedge clk); #1;
      pre_en  = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      logic [9:0] idx;
      idx = v.addr[11:2];
      preload(idx, v.init);
      bus.mem_re = v.re;
      bus.mem_we = v.we;
      bus.funct3 = v.f3;
      bus.addr   = v.addr;
      bus.wdata  = v.wdata;
      @(negedge clk);
      chk({v.nm, " c0 stall"}, 32'(bus.stall), 32'(v.stall0));
      chk({v.nm, " c0 ram_we"}, 32'(bus.ram_we), 32'(v.we0));
      chk({v.nm, " c0 ram_addr"}, 32'(bus.ram_addr), 32'(idx));
      chk({v.nm, " c0 load_valid"}, {bus.load_data[30:0], bus.load_valid}, 32'd0);
      if (v.we0) chk({v.nm, " c0 ram_din"}, bus.ram_din, v.din0);
      if (v.two) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({v.nm, " c1 stall"}, 32'(bus.stall), 32'd0);
         chk({v.nm, " c1 ram_we"}, 32'(bus.ram_we), 32'(v.we1));
         chk({v.nm, " c1 ram_addr"}, 32'(bus.ram_addr), 32'(idx));
         chk({v.nm, " c1 load_valid"}, 32'(bus.load_valid), 32'(v.lv1));
         chk({v.nm, " c1 load_data"}, bus.load_data, v.ld1);
         if (v.we1) chk({v.nm, " c1 ram_din"}, bus.ram_din, v.din1);
      end
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      chk({v.nm, " ram word"}, mem[idx], v.ram_fin);
      chk({v.nm, " misalign_err"}, 32'(bus.misalign_err), 32'(v.err));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      pre_en = 1'b0;
      pre_idx = 10'd0;
      pre_val = 32'd0;
      bus.ram_dout = 32'd0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

      //         nm        re  we  f3      addr          wdata          init          two stl0 we0 din0          we1 din1          lv1 ld1           ram_fin       err
      vecs[0]  = '{"SW",    0, 1, 3'b010, 32'h10,  32'hAABBCCDD, 32'h0,        0, 0, 1, 32'hAABBCCDD, 0, 32'h0,        0, 32'h0,        32'hAABBCCDD, 0};
      vecs[1]  = '{"SB12",  0, 1, 3'b000, 32'h12,  32'h000000EE, 32'h11223344, 1, 1, 0, 32'h0,        1, 32'h11EE3344, 0, 32'h0,        32'h11EE3344, 0};
      vecs[2]  = '{"LB13",  1, 0, 3'b000, 32'h13,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFF80, 32'h80223344, 0};
      vecs[3]  = '{"LBU13", 1, 0, 3'b100, 32'h13,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000080, 32'h80223344, 0};
      vecs[4]  = '{"LH12",  1, 0, 3'b001, 32'h12,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF8022, 32'h80223344, 0};
      vecs[5]  = '{"LHU12", 1, 0, 3'b101, 32'h12,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00008022, 32'h80223344, 0};
      vecs[6]  = '{"SH12",  0, 1, 3'b001, 32'h12,  32'h00005566, 32'h80223344, 1, 1, 0, 32'h0,        1, 32'h55663344, 0, 32'h0,        32'h55663344, 0};
      vecs[7]  = '{"LW10",  1, 0, 3'b010, 32'h10,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80223344, 32'h80223344, 0};
      vecs[8]  = '{"LB11",  1, 0, 3'b000, 32'h11,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000033, 32'h80223344, 0};
      vecs[9]  = '{"LH10",  1, 0, 3'b001, 32'h10,  32'h0,        32'h1234F00D, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFF00D, 32'h1234F00D, 0};
      vecs[10] = '{"SB10",  0, 1, 3'b000, 32'h10,  32'h123456AB, 32'h80223344, 1, 1, 0, 32'h0,        1, 32'h802233AB, 0, 32'h0,        32'h802233AB, 0};
      vecs[11] = '{"SH10",  0, 1, 3'b001, 32'h10,  32'hFFFF7788, 32'h80223344, 1, 1, 0, 32'h0,        1, 32'h80227788, 0, 32'h0,        32'h80227788, 0};
      vecs[12] = '{"SWtop", 0, 1, 3'b010, 32'h3FC, 32'h0BADF00D, 32'h0,        0, 0, 1, 32'h0BADF00D, 0, 32'h0,        0, 32'h0,        32'h0BADF00D, 0};
      vecs[13] = '{"SH11e", 0, 1, 3'b001, 32'h11,  32'h00001234, 32'h55555555, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h55555555, 1};
      vecs[14] = '{"LW12e", 1, 0, 3'b010, 32'h12,  32'h0,        32'h55555555, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h55555555, 1};
      vecs[15] = '{"L011e", 1, 0, 3'b011, 32'h10,  32'h0,        32'h55555555, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h55555555, 1};
      vecs[16] = '{"RWe",   1, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h55555555, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h55555555, 1};
      vecs[17] = '{"LBpost",1, 0, 3'b000, 32'h13,  32'h0,        32'h80223344, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFF80, 32'h80223344, 1};

      // Reset asserted with a store already on the bus: nothing may leak out.
      rst = 1'b1;
      clear_req();
      bus.mem_we = 1'b1;
      bus.funct3 = 3'b010;
      bus.addr   = 32'h10;
      bus.wdata  = 32'h12345678;
      #12;
      chk("rst ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst stall", 32'(bus.stall), 32'd0);
      chk("rst load_valid", 32'(bus.load_valid), 32'd0);
      chk("rst load_data", bus.load_data, 32'd0);
      chk("rst misalign_err", 32'(bus.misalign_err), 32'd0);
      @(negedge clk);
      clear_req();
      rst = 1'b0;

      // Requests presented while a load is in flight are ignored.
      preload(10'd4, 32'h80223344);
      bus.mem_re = 1'b1;
      bus.funct3 = 3'b000;
      bus.addr   = 32'h13;
      @(posedge clk); #1;
      bus.mem_re = 1'b0;
      bus.mem_we = 1'b1;
      bus.funct3 = 3'b010;
      bus.addr   = 32'h10;
      bus.wdata  = 32'hDEADBEEF;
      @(negedge clk);
      chk("busy ram_we", 32'(bus.ram_we), 32'd0);
      chk("busy load_valid", 32'(bus.load_valid), 32'd1);
      chk("busy load_data", bus.load_data, 32'hFFFFFF80);
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      chk("busy ram word", mem[4], 32'h80223344);

      for (int i = 0; i < 18; i++) apply_vec(vecs[i]);

      // Reset during RMW_WAIT aborts the write and clears the sticky error.
      preload(10'd4, 32'h11223344);
      bus.mem_we = 1'b1;
      bus.funct3 = 3'b000;
      bus.addr   = 32'h12;
      bus.wdata  = 32'h000000EE;
      @(posedge clk); #1;
      chk("rmw pre-rst ram_we", 32'(bus.ram_we), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rmw rst ram_we", 32'(bus.ram_we), 32'd0);
      chk("rmw rst stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      rst = 1'b0;
      chk("rmw rst ram word", mem[4], 32'h11223344);
      chk("rmw rst misalign_err", 32'(bus.misalign_err), 32'd0);
      @(posedge clk); #1;
      bus.mem_re = 1'b1;
      bus.funct3 = 3'b010;
      bus.addr   = 32'h10;
      @(negedge clk);
      chk("post-rst idle stall", 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post-rst LW data", bus.load_data, 32'h11223344);
      @(posedge clk); #1;
      clear_req();
      @(negedge clk);
      chk("post-rst idle", {30'd0, bus.stall, bus.load_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: RAM_AW, default 10, RAM word-address width; ram_addr = addr[RAM_AW+1:2].
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_re  input  1  CPU MEM-stage load request.
REQ-005 mem_we  input  1  CPU MEM-stage store request.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address from CPU.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 load_data  output  32  extended load result.
REQ-010 load_valid  output  1  load_data valid this cycle.
REQ-011 stall  output  1  hold PC/IF/ID/EX/MEM this cycle.
REQ-012 misalign_err  output  1  sticky error flag.
REQ-013 ram_addr  output  RAM_AW  RAM word address.
REQ-014 ram_din  output  32  RAM write data.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 ram_dout  input  32  RAM read data, valid one cycle after ram_addr is presented.

Function
REQ-017 FSM states: IDLE, LOAD_WAIT, RMW_WAIT; every legal access takes at most 2 cycles.
REQ-018 IDLE, mem_we, funct3=010, aligned: ram_we=1, ram_din=wdata, stall=0, stay IDLE.
REQ-019 IDLE, mem_we, funct3 000/001, aligned: ram_we=0, stall=1, latch addr[1:0]/wdata/funct3, go RMW_WAIT.
REQ-020 RMW_WAIT: ram_we=1, ram_din=ram_dout with selected byte/halfword lane replaced by latched wdata low bits, stall=0, go IDLE.
REQ-021 Lane select: byte lane = addr[1:0]; halfword lane = addr[1] (bits 15:0 or 31:16).
REQ-022 IDLE, mem_re, legal aligned funct3: stall=1, latch addr[1:0]/funct3, go LOAD_WAIT.
REQ-023 LOAD_WAIT: load_valid=1, load_data=extracted lane, sign-extended (000/001) or zero-extended (100/101), full word for 010; stall=0, go IDLE.
REQ-024 load_data=0 and load_valid=0 in all other cycles.
REQ-025 ram_addr is driven from addr in IDLE and from the latched address in LOAD_WAIT/RMW_WAIT.
REQ-026 Misaligned (H with addr[0]=1, W with addr[1:0]!=00), illegal funct3, or mem_re&mem_we both 1: no RAM write, stall=0, stay IDLE, misalign_err set to 1 next edge.
REQ-027 misalign_err stays 1 until reset.
REQ-028 mem_re/mem_we ignored outside IDLE; request inputs are sampled only in IDLE.
REQ-029 No request in IDLE: ram_we=0, stall=0.

Reset
REQ-030 rst=1 forces state IDLE, misalign_err=0, and latches cleared, regardless of clk.
REQ-031 While rst=1: ram_we=0, stall=0, load_valid=0, load_data=0.
REQ-032 Reset during LOAD_WAIT/RMW_WAIT aborts the access; no partial write reaches RAM.

Verification
REQ-033 SW wdata=0xAABBCCDD, addr=0x10 -> same cycle ram_we=1, ram_addr=4, ram_din=0xAABBCCDD, stall=0.
REQ-034 RAM[4]=0x11223344, SB wdata=0x000000EE, addr=0x12 -> cycle0 stall=1, ram_we=0; cycle1 ram_we=1, ram_din=0x11EE3344, stall=0.
REQ-035 RAM[4]=0x80223344, LB addr=0x13 -> cycle0 stall=1; cycle1 load_valid=1, load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-036 RAM[4]=0x80223344, LH addr=0x12 -> load_data=0xFFFF8022; SH addr=0x12 wdata=0x5566 -> ram_din=0x55663344.
REQ-037 SH addr=0x11 -> ram_we=0, stall=0, misalign_err=1 next cycle and held across later legal accesses.
REQ-038 SB issued, rst asserted in RMW_WAIT -> ram_we=0 immediately, state IDLE, RAM[4] unchanged.
